// File: rtl/add_res_station_pkg.sv
// Shared definitions for the add/sub reservation station: CDB tags, op
// encodings, FSM state encoding and the functional-unit arithmetic.
package add_res_station_pkg;

  localparam logic [2:0] FREE_REGISTER    = 3'd0;
  localparam logic [2:0] RES_STATION_ADD1 = 3'd1;
  localparam logic [2:0] RES_STATION_ADD2 = 3'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    EXEC     = 2'd2,
    DONE     = 2'd3
  } rs_state_e;

  // 16-bit modulo add/sub; carry and borrow are dropped.
  function automatic logic [15:0] fu_result(input logic op, input logic [15:0] a,
                                            input logic [15:0] b);
    return (op == OP_SUB) ? (a - b) : (a + b);
  endfunction

  // Signed overflow: operands (b negated for sub) share a sign that the result lacks.
  function automatic logic fu_ovf(input logic op, input logic [15:0] a,
                                  input logic [15:0] b, input logic [15:0] r);
    logic same_sign;
    same_sign = (op == OP_SUB) ? (a[15] != b[15]) : (a[15] == b[15]);
    return same_sign && (r[15] != a[15]);
  endfunction

endpackage

// File: rtl/add_res_station_operand_slot.sv
// One operand slot (V/Q pair) of the reservation station. Captures the issued
// operand, resolving it immediately if the CDB broadcasts its producer in the
// issue cycle, and otherwise snoops the CDB while the station waits.
module rs_operand_slot
  import add_res_station_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        issue_load,
  input  logic        snoop_en,
  input  logic [15:0] issue_v,
  input  logic [2:0]  issue_q,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [15:0] cdb_data,
  output logic [15:0] v,
  output logic        ready_nxt
);

  logic [2:0]  q;
  logic [15:0] v_nxt;
  logic [2:0]  q_nxt;

  // Next V/Q: issue capture with same-cycle bypass, else CDB snoop.
  always_comb begin
    v_nxt = v;
    q_nxt = q;
    if (issue_load) begin
      if (issue_q != FREE_REGISTER && cdb_valid && cdb_tag == issue_q) begin
        v_nxt = cdb_data;
        q_nxt = FREE_REGISTER;
      end else begin
        v_nxt = issue_v;
        q_nxt = issue_q;
      end
    end else if (snoop_en && q != FREE_REGISTER && cdb_valid && cdb_tag == q) begin
      v_nxt = cdb_data;
      q_nxt = FREE_REGISTER;
    end
    ready_nxt = (q_nxt == FREE_REGISTER);
  end

  // V/Q storage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      v <= '0;
      q <= FREE_REGISTER;
    end else begin
      v <= v_nxt;
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/add_res_station.sv
// Reservation station with integrated 16-bit add/sub unit.
// Optional feature: define ADD_RS_OVF_EN to add the registered Ovf output.
module add_res_station
  import add_res_station_pkg::*;
#(
  parameter logic [2:0] TAG          = RES_STATION_ADD1,
  parameter int         EXEC_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Issue_Valid,
  input  logic        Issue_Op,
  input  logic [15:0] Issue_Vj,
  input  logic [15:0] Issue_Vk,
  input  logic [2:0]  Issue_Qj,
  input  logic [2:0]  Issue_Qk,
  input  logic        CDB_Valid,
  input  logic [2:0]  CDB_Tag,
  input  logic [15:0] CDB_Data,
  input  logic        Grant,
  output logic        Busy,
  output logic        Done,
`ifdef ADD_RS_OVF_EN
  output logic        Ovf,
`endif
  output logic [15:0] Q
);

  localparam int CNT_W = (EXEC_LATENCY > 2) ? $clog2(EXEC_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_LATENCY - 1);

  rs_state_e        state, state_nxt;
  logic             issue_acc, fire;
  logic             op;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      vj, vk, res;
  logic             rdy_j, rdy_k;

  rs_operand_slot u_slot_j (
    .Clock(Clock), .Reset(Reset), .issue_load(issue_acc), .snoop_en(state == WAIT_OPS),
    .issue_v(Issue_Vj), .issue_q(Issue_Qj), .cdb_valid(CDB_Valid), .cdb_tag(CDB_Tag),
    .cdb_data(CDB_Data), .v(vj), .ready_nxt(rdy_j)
  );

  rs_operand_slot u_slot_k (
    .Clock(Clock), .Reset(Reset), .issue_load(issue_acc), .snoop_en(state == WAIT_OPS),
    .issue_v(Issue_Vk), .issue_q(Issue_Qk), .cdb_valid(CDB_Valid), .cdb_tag(CDB_Tag),
    .cdb_data(CDB_Data), .v(vk), .ready_nxt(rdy_k)
  );

  assign res = fu_result(op, vj, vk);

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; rdy_j/rdy_k already reflect bypass/snoop results of this edge.
  always_comb begin
    state_nxt = state;
    issue_acc = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (Issue_Valid) begin
          issue_acc = 1'b1;
          state_nxt = (rdy_j && rdy_k) ? EXEC : WAIT_OPS;
        end
      end
      WAIT_OPS: if (rdy_j && rdy_k) state_nxt = EXEC;
      EXEC: begin
        if (cnt == '0) begin
          fire      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    if (Grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: loaded on EXEC entry, counts down to the fire point.
  always_ff @(posedge Clock) begin
    if (Reset)                                  cnt <= '0;
    else if (state_nxt == EXEC && state != EXEC) cnt <= CNT_LOAD;
    else if (state == EXEC && cnt != '0)        cnt <= cnt - CNT_W'(1);
  end

  // Latched opcode.
  always_ff @(posedge Clock) begin
    if (Reset)          op <= OP_ADD;
    else if (issue_acc) op <= Issue_Op;
  end

  // Registered outputs; Q (and Ovf) keep their value after Grant.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Busy <= 1'b0;
      Done <= 1'b0;
      Q    <= '0;
`ifdef ADD_RS_OVF_EN
      Ovf  <= 1'b0;
`endif
    end else begin
      Busy <= (state_nxt != IDLE);
      Done <= (state_nxt == DONE);
      if (fire) begin
        Q   <= res;
`ifdef ADD_RS_OVF_EN
        Ovf <= fu_ovf(op, vj, vk, res);
`endif
      end
    end
  end

  // A station must never wait on its own tag.
  a_no_self_tag: assert property (@(posedge Clock) disable iff (Reset)
    (Issue_Valid && state == IDLE) |-> (Issue_Qj != TAG && Issue_Qk != TAG));

endmodule

// File: tb/tb_add_res_station.sv
// Directed, table-driven bench for add_res_station (TAG=1, EXEC_LATENCY=2).
module tb_add_res_station;

  localparam int LAT = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Issue_Valid, Issue_Op;
  logic [15:0] Issue_Vj, Issue_Vk;
  logic [2:0]  Issue_Qj, Issue_Qk;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic        Grant;
  logic        Busy, Done;
  logic [15:0] Q;
`ifdef ADD_RS_OVF_EN
  logic        Ovf;
`endif

  int checks = 0;
  int errors = 0;

  add_res_station #(.TAG(3'd1), .EXEC_LATENCY(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .Issue_Valid(Issue_Valid), .Issue_Op(Issue_Op),
    .Issue_Vj(Issue_Vj), .Issue_Vk(Issue_Vk), .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
    .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data), .Grant(Grant),
    .Busy(Busy), .Done(Done),
`ifdef ADD_RS_OVF_EN
    .Ovf(Ovf),
`endif
    .Q(Q)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        op;
    logic [15:0] vj, vk;
    logic [2:0]  qj, qk;
    logic        byp;
    int          dly;
    logic [2:0]  ctag;
    logic [15:0] cdata;
    logic [15:0] exp_q;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Issue_Valid = 1'b0; Issue_Op = 1'b0; Issue_Vj = '0; Issue_Vk = '0;
    Issue_Qj = '0; Issue_Qk = '0; CDB_Valid = 1'b0; CDB_Tag = '0; CDB_Data = '0;
    Grant = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge Clock);
    Issue_Valid = 1'b1; Issue_Op = v.op; Issue_Vj = v.vj; Issue_Vk = v.vk;
    Issue_Qj = v.qj; Issue_Qk = v.qk;
    if (v.byp) begin
      CDB_Valid = 1'b1; CDB_Tag = v.ctag; CDB_Data = v.cdata;
    end
    @(negedge Clock);
    idle_inputs();
    chk($sformatf("v%0d busy_after_issue", idx), 32'(Busy), 32'd1);
    if (!v.byp && v.ctag != 3'd0) begin
      // Unrelated broadcasts and stray Grant while waiting must be ignored.
      for (int i = 0; i < v.dly; i++) begin
        CDB_Valid = 1'b1; CDB_Tag = (v.ctag == 3'd2) ? 3'd3 : 3'd2; CDB_Data = 16'hDEAD;
        Grant = 1'b1;
        @(negedge Clock);
      end
      chk($sformatf("v%0d waiting_no_done", idx), 32'(Done), 32'd0);
      CDB_Valid = 1'b1; CDB_Tag = v.ctag; CDB_Data = v.cdata; Grant = 1'b0;
      @(negedge Clock);
      idle_inputs();
    end
    wait_done(n);
    chk($sformatf("v%0d latency", idx), 32'(n), 32'(LAT));
    chk($sformatf("v%0d q", idx), 32'(Q), 32'(v.exp_q));
`ifdef ADD_RS_OVF_EN
    chk($sformatf("v%0d ovf", idx), 32'(Ovf), 32'(v.exp_ovf));
`endif
    Grant = 1'b1;
    @(negedge Clock);
    Grant = 1'b0;
    chk($sformatf("v%0d done_cleared", idx), 32'(Done), 32'd0);
    chk($sformatf("v%0d busy_cleared", idx), 32'(Busy), 32'd0);
    chk($sformatf("v%0d q_retained", idx), 32'(Q), 32'(v.exp_q));
  endtask

  initial begin
    int n;
    logic seen_done;
    //           op    vj        vk        qj    qk    byp  dly ctag  cdata     exp_q     ovf
    vecs[0] = '{1'b0, 16'h0003, 16'h0004, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 16'h0007, 1'b0};
    vecs[1] = '{1'b1, 16'h0010, 16'h9999, 3'd0, 3'd2, 1'b0, 2, 3'd2, 16'h0001, 16'h000F, 1'b0};
    vecs[2] = '{1'b0, 16'hAAAA, 16'h0001, 3'd2, 3'd0, 1'b1, 0, 3'd2, 16'h1234, 16'h1235, 1'b0};
    vecs[3] = '{1'b0, 16'hFFFF, 16'h0002, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 16'h0001, 1'b0};
    vecs[4] = '{1'b0, 16'h1111, 16'h2222, 3'd2, 3'd2, 1'b0, 1, 3'd2, 16'h0005, 16'h000A, 1'b0};
    vecs[5] = '{1'b1, 16'h0000, 16'h0001, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 16'hFFFF, 1'b0};
    vecs[6] = '{1'b1, 16'h1111, 16'h0100, 3'd3, 3'd0, 1'b0, 0, 3'd3, 16'h0050, 16'hFF50, 1'b0};
    vecs[7] = '{1'b0, 16'h7FFF, 16'h0001, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 16'h8000, 1'b1};
    vecs[8] = '{1'b1, 16'h8000, 16'h0001, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0000, 16'h7FFF, 1'b1};

    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset done", 32'(Done), 32'd0);
    chk("reset q", 32'(Q), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Long Grant delay with an issue attempt while DONE.
    @(negedge Clock);
    Issue_Valid = 1'b1; Issue_Op = 1'b0; Issue_Vj = 16'h0003; Issue_Vk = 16'h0004;
    @(negedge Clock);
    idle_inputs();
    wait_done(n);
    chk("hold latency", 32'(n), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        Issue_Valid = 1'b1; Issue_Vj = 16'h0100; Issue_Vk = 16'h0200;
      end
      @(negedge Clock);
      Issue_Valid = 1'b0;
      chk($sformatf("hold done c%0d", i), 32'(Done), 32'd1);
      chk($sformatf("hold q c%0d", i), 32'(Q), 32'h0007);
    end
    Grant = 1'b1;
    @(negedge Clock);
    Grant = 1'b0;
    chk("hold grant busy", 32'(Busy), 32'd0);
    @(negedge Clock);
    chk("hold no queued issue", 32'(Busy), 32'd0);
    chk("hold q after", 32'(Q), 32'h0007);

    // Reset one cycle after issue, while in EXEC.
    Issue_Valid = 1'b1; Issue_Vj = 16'h0001; Issue_Vk = 16'h0001;
    @(negedge Clock);
    idle_inputs();
    chk("rst_exec busy_before", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("rst_exec busy", 32'(Busy), 32'd0);
    chk("rst_exec done", 32'(Done), 32'd0);
    chk("rst_exec q", 32'(Q), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) seen_done = 1'b1;
    end
    chk("rst_exec no_done", 32'(seen_done), 32'd0);

    // Normal operation resumes after reset.
    run_vec(vecs[1], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
